// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN layer chain controllers.
package cnn_pkg;

    // Default channel sample width and channel count of the layer chain.
    localparam int DEF_D_WIDTH  = 8;
    localparam int DEF_CHANNELS = 3;

    // Width of one pixel on every stream in the chain.
    localparam int PIXEL_W = DEF_D_WIDTH * DEF_CHANNELS;

    // Frame-level sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Output edge length of a window layer with no padding.
    function automatic int out_size(input int image, input int filter, input int stride);
        return (image - filter) / stride + 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_raster_counter.sv
// Raster position counter: column, row and linear index of the next pixel,
// with synchronous clear (priority over enable) and a flag for the last pixel.
module raster_counter #(
    parameter int COLS  = 256,
    parameter int ROWS  = 256,
    parameter int COL_W = 8,
    parameter int ROW_W = 8,
    parameter int IDX_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COLS * ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Next position: clear wins, otherwise step in raster order when enabled.
    always_comb begin
        idx_d = idx_q;
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            idx_d = '0;
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            idx_d = idx_q + IDX_ONE;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
            end else begin
                col_d = col_q + COL_ONE;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            idx_q <= idx_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (idx_q == IDX_LAST);

endmodule

// File: rtl/layer_sequencer.sv
// Frame-level controller for one CNN layer. Gates the layer clock so it only
// advances on accepted input pixels or zero-padded drain beats, and holds
// each layer result until downstream takes it.
//
// Handshakes: a beat transfers on a cycle where valid & ready are both high
// at the rising clock edge; valid never depends on ready of the same stream.
// in_ready also drops during abort so no pixel is consumed by an aborted
// frame.
module layer_sequencer
    import cnn_pkg::*;
#(
    parameter int D_WIDTH     = DEF_D_WIDTH,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int IMAGE_SIZE  = 256,
    parameter int FILTER_SIZE = 2,
    parameter int STRIDE      = 1,
    parameter int DRAIN_MAX   = 1024
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     abort,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     timeout,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [D_WIDTH*CHANNELS-1:0]              in_data,
    output logic                                     layer_clk_en,
    output logic [D_WIDTH*CHANNELS-1:0]              layer_data,
    input  logic [D_WIDTH*CHANNELS-1:0]              layer_q,
    input  logic                                     layer_valid,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [D_WIDTH*CHANNELS-1:0]              out_data,
    output logic [$clog2(IMAGE_SIZE)-1:0]            in_row,
    output logic [$clog2(IMAGE_SIZE)-1:0]            in_col,
    output logic [1:0]                               dbg_state
);

    localparam int OUT_SIZE   = out_size(IMAGE_SIZE, FILTER_SIZE, STRIDE);
    localparam int IN_PIXELS  = IMAGE_SIZE * IMAGE_SIZE;
    localparam int OUT_PIXELS = OUT_SIZE * OUT_SIZE;
    localparam int CNT_W      = $clog2(IN_PIXELS + 1);
    localparam int POS_W      = $clog2(IMAGE_SIZE);
    localparam int DRN_W      = $clog2(DRAIN_MAX + 1);

    localparam logic [CNT_W-1:0] OUT_TARGET = CNT_W'(OUT_PIXELS);
    localparam logic [DRN_W-1:0] DRN_LIMIT  = DRN_W'(DRAIN_MAX);

    seq_state_t       state_q, state_d;
    logic             fresh_q, fresh_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;

    logic             can_adv;
    logic             fire;
    logic             feed_fire;
    logic             drain_fire;
    logic             out_room;
    logic             out_acc;
    logic             out_full;
    logic             drain_exp;
    logic             start_go;
    logic             abort_go;
    logic             ctr_clr;
    logic             in_last;
    logic [CNT_W-1:0] out_cnt_inc;
    logic [DRN_W-1:0] drain_inc;

    // Handshake, fire and output-stream decode shared by the FSM and counters.
    always_comb begin
        busy       = (state_q == FEED) || (state_q == DRAIN);
        abort_go   = abort && (state_q != IDLE);
        start_go   = (state_q == IDLE) && start && !abort;
        // One-deep hold: the layer may only advance when its last result
        // has been taken or was never produced.
        can_adv    = !fresh_q || out_ready;
        in_ready   = (state_q == FEED) && can_adv && !abort;
        feed_fire  = in_valid && in_ready;
        drain_fire = (state_q == DRAIN) && can_adv && !abort;
        fire       = feed_fire || drain_fire;
        // Once the expected output count is met, surplus results are held back.
        out_room   = (out_cnt_q < OUT_TARGET);
        out_valid  = fresh_q && layer_valid && busy && out_room;
        out_acc    = out_valid && out_ready;
        out_cnt_inc = out_cnt_q + {{(CNT_W-1){1'b0}}, out_acc};
        drain_inc   = drain_cnt_q + {{(DRN_W-1){1'b0}}, drain_fire};
        out_full    = (out_cnt_inc >= OUT_TARGET);
        drain_exp   = (drain_inc >= DRN_LIMIT);
        ctr_clr     = start_go || abort_go;
    end

    assign layer_clk_en = fire;
    assign layer_data   = (state_q == FEED) ? in_data : '0;
    assign out_data     = layer_q;
    assign timeout      = timeout_q;
    assign done         = (state_q == DONE) && !abort;
    assign dbg_state    = state_q;

    raster_counter #(
        .COLS  (IMAGE_SIZE),
        .ROWS  (IMAGE_SIZE),
        .COL_W (POS_W),
        .ROW_W (POS_W),
        .IDX_W (CNT_W)
    ) u_in_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .en   (feed_fire),
        .row  (in_row),
        .col  (in_col),
        .last (in_last)
    );

    // Next-state, result-hold flag and frame counters; abort overrides all.
    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q;
        out_cnt_d   = out_cnt_inc;
        drain_cnt_d = drain_inc;
        if (fire) begin
            fresh_d = 1'b1;
        end else if (out_ready) begin
            fresh_d = 1'b0;
        end else begin
            fresh_d = fresh_q;
        end

        case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d     = FEED;
                    timeout_d   = 1'b0;
                    fresh_d     = 1'b0;
                    out_cnt_d   = '0;
                    drain_cnt_d = '0;
                end
            end
            FEED: begin
                if (feed_fire && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Completing the output count beats the drain limit on a tie.
                if (out_full) begin
                    state_d = DONE;
                end else if (drain_exp) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_go) begin
            state_d     = IDLE;
            fresh_d     = 1'b0;
            out_cnt_d   = '0;
            drain_cnt_d = '0;
        end
    end

    // State and frame bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fresh_q     <= 1'b0;
            timeout_q   <= 1'b0;
            out_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fresh_q     <= fresh_d;
            timeout_q   <= timeout_d;
            out_cnt_q   <= out_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer on a 4x4 frame, 2x2 window, stride 1.
module tb_layer_sequencer;
  import cnn_pkg::*;

  localparam int IMG  = 4;
  localparam int DMAX = 8;
  localparam int PW   = 24;
  localparam int NIN  = 16;
  localparam int NOUT = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, busy, done, timeout;
  logic          in_valid, in_ready;
  logic [PW-1:0] in_data;
  logic          layer_clk_en;
  logic [PW-1:0] layer_data, layer_q;
  logic          layer_valid;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_data;
  logic [1:0]    in_row, in_col, dbg_state;

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];

  int   frame_id = 0;
  int   next_idx = 0;
  int   cyc = 0;
  int   vpct = 100;
  int   rdiv = 1;
  logic hold_start = 1'b0;
  int   feed_fires, drain_fires, feed_bad, pos_bad, drain_bad, early_drain;
  int   bp_viol, done_cnt, done_busy;
  logic ab_fire, ab_done, done_to, to_after_start, busy_after_start;
  logic fresh_m = 1'b0;
  int   valid_idx[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

  // clock / reset
  always #5 clk = ~clk;

  layer_sequencer #(
    .D_WIDTH(8), .CHANNELS(3), .IMAGE_SIZE(IMG), .FILTER_SIZE(2),
    .STRIDE(1), .DRAIN_MAX(DMAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
    .done(done), .timeout(timeout), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .layer_clk_en(layer_clk_en), .layer_data(layer_data),
    .layer_q(layer_q), .layer_valid(layer_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .in_row(in_row),
    .in_col(in_col), .dbg_state(dbg_state)
  );

  // layer model: 5-stage pipe advanced by layer_clk_en; a result is valid
  // when the pixel it carries is the bottom-right corner of a 2x2 window
  logic [PW-1:0] lm_data[5];
  logic          lm_ok[5];
  int            lm_cnt;
  logic          lm_clr = 1'b1;
  logic          lm_never = 1'b0;

  always @(posedge clk) begin
    if (lm_clr) begin
      for (int k = 0; k < 5; k++) begin
        lm_data[k] <= '0;
        lm_ok[k]   <= 1'b0;
      end
      lm_cnt <= 0;
    end else if (layer_clk_en) begin
      for (int k = 4; k > 0; k--) begin
        lm_data[k] <= lm_data[k-1];
        lm_ok[k]   <= lm_ok[k-1];
      end
      lm_data[0] <= layer_data;
      lm_ok[0]   <= !lm_never && (lm_cnt < NIN) && ((lm_cnt / 4) >= 1) && ((lm_cnt % 4) >= 1);
      lm_cnt     <= lm_cnt + 1;
    end
  end

  assign layer_q     = lm_data[4];
  assign layer_valid = lm_ok[4];

  function automatic logic [PW-1:0] pix(input int f, input int i);
    logic [7:0] fb;
    logic [7:0] ib;
    fb = f[7:0];
    ib = i[7:0];
    return {fb, ib, ib ^ 8'hA5};
  endfunction

  // driver: one clock cycle of stimulus, then sample at the falling edge
  task automatic step(input logic st, input logic ab);
    @(posedge clk);
    #1;
    start     = st | hold_start;
    abort     = ab;
    in_valid  = (next_idx < NIN) && ($urandom_range(0, 99) < vpct);
    in_data   = in_valid ? pix(frame_id, next_idx) : {PW{1'b1}};
    out_ready = (rdiv <= 1) ? 1'b1 : ((cyc % rdiv) == 0);
    cyc++;
    @(negedge clk);
    if (in_ready && ((in_valid && in_ready) != layer_clk_en)) feed_bad++;
    if (layer_clk_en && in_ready) begin
      feed_fires++;
      if (layer_data !== pix(frame_id, next_idx)) feed_bad++;
      if (in_row !== next_idx[3:2] || in_col !== next_idx[1:0]) pos_bad++;
      next_idx++;
    end
    if (layer_clk_en && !in_ready) begin
      drain_fires++;
      if (layer_data !== '0) drain_bad++;
      if (feed_fires < NIN) early_drain++;
    end
    if (layer_clk_en && fresh_m && !out_ready) bp_viol++;
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (done) begin
      done_cnt++;
      done_to = timeout;
      if (busy) done_busy++;
    end
    if (ab) begin
      ab_fire = layer_clk_en;
      ab_done = done;
    end
    if (ab) fresh_m = 1'b0;
    else if (start && !busy && !done) fresh_m = 1'b0;
    else if (layer_clk_en) fresh_m = 1'b1;
    else if (out_ready) fresh_m = 1'b0;
  endtask

  // driver: one frame from start to done (or abort at a pixel index)
  task automatic run_frame(input int abort_at, input logic noisy, input string name);
    int   n;
    logic aborted;
    feed_fires = 0; drain_fires = 0; feed_bad = 0; pos_bad = 0; drain_bad = 0;
    early_drain = 0; bp_viol = 0; done_cnt = 0; done_busy = 0; done_to = 1'b0;
    ab_fire = 1'b0; ab_done = 1'b0;
    got_q.delete();
    exp_q.delete();
    frame_id++;
    next_idx = 0;
    n = 0;
    aborted = 1'b0;
    for (int k = 0; k < NOUT; k++) exp_q.push_back(pix(frame_id, valid_idx[k]));
    lm_clr = 1'b1;
    step(1'b0, 1'b0);
    lm_clr = 1'b0;
    step(1'b1, 1'b0);
    hold_start = noisy;
    step(1'b0, 1'b0);
    to_after_start   = timeout;
    busy_after_start = busy;
    while (done_cnt == 0 && !aborted && n < 400) begin
      if (abort_at >= 0 && next_idx == abort_at) begin
        step(1'b0, 1'b1);
        aborted = 1'b1;
      end else begin
        step(1'b0, 1'b0);
      end
      n++;
    end
    hold_start = 1'b0;
    if (done_cnt == 0 && !aborted) begin
      checks++; failures++;
      $display("FAIL %s_bound: no done after %0d cycles, required done", name, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, timeout, in_ready, layer_clk_en, out_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 000000", {busy, done, timeout, in_ready, layer_clk_en, out_valid});
    end
    checks++;
    if ({in_row, in_col, dbg_state} !== 6'b0) begin
      failures++;
      $display("FAIL reset_position_state: got %b required 000000", {in_row, in_col, dbg_state});
    end
    rst = 1'b0;
    step(1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_hold: got busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_full_rate();
    vpct = 100; rdiv = 1;
    run_frame(-1, 1'b0, "full");
    checks++;
    if (busy_after_start !== 1'b1) begin failures++; $display("FAIL full_busy: got %b required 1", busy_after_start); end
    checks++;
    if (feed_fires != NIN || feed_bad != 0 || pos_bad != 0) begin
      failures++;
      $display("FAIL full_feed: got fires=%0d bad=%0d pos_bad=%0d required 16 0 0", feed_fires, feed_bad, pos_bad);
    end
    checks++;
    if (drain_fires != 5 || early_drain != 0 || drain_bad != 0) begin
      failures++;
      $display("FAIL full_drain: got fires=%0d early=%0d nonzero=%0d required 5 0 0", drain_fires, early_drain, drain_bad);
    end
    checks++;
    if (done_cnt != 1 || done_busy != 0 || done_to !== 1'b0) begin
      failures++;
      $display("FAIL full_done: got pulses=%0d busy_overlap=%0d timeout=%b required 1 0 0", done_cnt, done_busy, done_to);
    end
    step(1'b0, 1'b0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL full_done_len: got done=%b busy=%b required 0 0", done, busy); end
    checks++;
    if (got_q.size() != NOUT) begin failures++; $display("FAIL full_out_count: got %0d required %0d", got_q.size(), NOUT); end
    for (int k = 0; k < NOUT && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL full_out_%0d: got %h required %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    vpct = 100; rdiv = 3;
    run_frame(-1, 1'b1, "bp");
    checks++;
    if (bp_viol != 0) begin failures++; $display("FAIL bp_hold: got %0d enables while held required 0", bp_viol); end
    checks++;
    if (feed_fires != NIN || feed_bad != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL bp_frame: got fires=%0d bad=%0d done=%0d required 16 0 1", feed_fires, feed_bad, done_cnt);
    end
    checks++;
    if (got_q.size() != NOUT) begin failures++; $display("FAIL bp_out_count: got %0d required %0d", got_q.size(), NOUT); end
    for (int k = 0; k < NOUT && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL bp_out_%0d: got %h required %h", k, got_q[k], exp_q[k]); end
    end
    rdiv = 1;
  endtask

  task automatic test_upstream_gaps();
    vpct = 50; rdiv = 1;
    run_frame(-1, 1'b0, "gaps");
    checks++;
    if (feed_fires != NIN || feed_bad != 0 || pos_bad != 0) begin
      failures++;
      $display("FAIL gaps_feed: got fires=%0d bad=%0d pos_bad=%0d required 16 0 0", feed_fires, feed_bad, pos_bad);
    end
    checks++;
    if (drain_bad != 0 || drain_fires == 0) begin
      failures++;
      $display("FAIL gaps_drain_zero: got nonzero=%0d fires=%0d required 0 and >0", drain_bad, drain_fires);
    end
    checks++;
    if (got_q.size() != NOUT) begin failures++; $display("FAIL gaps_out_count: got %0d required %0d", got_q.size(), NOUT); end
    for (int k = 0; k < NOUT && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL gaps_out_%0d: got %h required %h", k, got_q[k], exp_q[k]); end
    end
    vpct = 100;
  endtask

  task automatic test_timeout();
    vpct = 100; rdiv = 1;
    lm_never = 1'b1;
    run_frame(-1, 1'b0, "timeout");
    lm_never = 1'b0;
    checks++;
    if (drain_fires != DMAX || done_cnt != 1 || done_to !== 1'b1) begin
      failures++;
      $display("FAIL timeout_set: got drain=%0d done=%0d timeout=%b required 8 1 1", drain_fires, done_cnt, done_to);
    end
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL timeout_no_out: got %0d required 0", got_q.size()); end
    step(1'b0, 1'b0);
    checks++;
    if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b required 1", timeout); end
    run_frame(-1, 1'b0, "timeout_clear");
    checks++;
    if (to_after_start !== 1'b0 || done_to !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: got %b/%b required 0/0", to_after_start, done_to);
    end
    checks++;
    if (got_q.size() != NOUT) begin failures++; $display("FAIL timeout_next_frame: got %0d outputs required %0d", got_q.size(), NOUT); end
  endtask

  task automatic test_abort();
    vpct = 100; rdiv = 1;
    run_frame(7, 1'b0, "abort");
    checks++;
    if (ab_fire !== 1'b0 || ab_done !== 1'b0 || done_cnt != 0 || feed_fires != 7) begin
      failures++;
      $display("FAIL abort_cycle: got en=%b done=%b pulses=%0d fires=%0d required 0 0 0 7", ab_fire, ab_done, done_cnt, feed_fires);
    end
    step(1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || in_row !== 2'd0 || in_col !== 2'd0) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b in_ready=%b done=%b row=%0d col=%0d required 0 0 0 0 0", busy, in_ready, done, in_row, in_col);
    end
    run_frame(-1, 1'b0, "after_abort");
    checks++;
    if (feed_fires != NIN || done_cnt != 1 || got_q.size() != NOUT) begin
      failures++;
      $display("FAIL abort_restart: got fires=%0d done=%0d outs=%0d required 16 1 9", feed_fires, done_cnt, got_q.size());
    end
    for (int k = 0; k < NOUT && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL abort_out_%0d: got %h required %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    vpct = 100; rdiv = 1;
    feed_fires = 0; drain_fires = 0; n = 0;
    frame_id++;
    next_idx = 0;
    lm_clr = 1'b1;
    step(1'b0, 1'b0);
    lm_clr = 1'b0;
    step(1'b1, 1'b0);
    while (drain_fires < 2 && n < 100) begin
      step(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (drain_fires < 2) begin failures++; $display("FAIL rst_reach_drain: got %0d drain fires required 2", drain_fires); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, layer_clk_en, in_ready, done} !== 5'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL rst_async: got %b state=%0d required 00000 state=0", {busy, out_valid, layer_clk_en, in_ready, done}, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    fresh_m = 1'b0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL start_abort_idle: got busy=%b state=%0d required 0 0", busy, dbg_state);
    end
    run_frame(-1, 1'b0, "post_reset");
    checks++;
    if (busy_after_start !== 1'b1 || feed_fires != NIN || done_cnt != 1 || got_q.size() != NOUT) begin
      failures++;
      $display("FAIL post_reset_frame: got busy=%b fires=%0d done=%0d outs=%0d required 1 16 1 9", busy_after_start, feed_fires, done_cnt, got_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_full_rate();
    test_backpressure();
    test_upstream_gaps();
    test_timeout();
    test_abort();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
